sdram_req_queue: RTL

SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

---
 rtl/sdram_pkg.sv | 42 ++++
 rtl/sdram_req_queue_if.sv | 38 +++
 rtl/sdram_sync_fifo.sv | 60 ++++++
 rtl/sdram_req_queue.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request queue: the stored request entry and the sequencer states.
// Entry fields are sized for the widest supported core; narrower cores use the low bits.
package sdram_pkg;

  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxBeWidth   = MaxDataWidth / 8;
  localparam int unsigned MaxAddrWidth = 32;
  localparam int unsigned MaxTagWidth  = 8;

  typedef struct packed {
    logic                    rd;
    logic [MaxBeWidth-1:0]   wr;
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxDataWidth-1:0] wdata;
    logic [MaxTagWidth-1:0]  tag;
  } req_entry_t;

  typedef enum logic [0:0] {
    StIdle,
    StWaitRd
  } req_state_e;

  // A read carrying byte enables is still a read: the enables are dropped.
  function automatic req_entry_t make_entry(input logic                    rd,
                                            input logic [MaxBeWidth-1:0]   wr,
                                            input logic [MaxAddrWidth-1:0] addr,
                                            input logic [MaxDataWidth-1:0] wdata,
                                            input logic [MaxTagWidth-1:0]  tag);
    req_entry_t e;
    e.rd    = rd;
    e.wr    = rd ? '0 : wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.tag   = tag;
    return e;
  endfunction

  function automatic logic is_real_req(input logic rd, input logic [MaxBeWidth-1:0] wr);
    return rd | (|wr);
  endfunction

endpackage

// File: rtl/sdram_req_queue_if.sv
// Request/response bus between the request queue (man) and the SDRAM controller core (sub).
interface sdram_req_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                    rd;
  logic [DATA_WIDTH/8-1:0] wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    rdy;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    error;

  modport man (
    output rd,
    output wr,
    output addr,
    output write_data,
    input  rdy,
    input  valid,
    input  read_data,
    input  error
  );

  modport sub (
    input  rd,
    input  wr,
    input  addr,
    input  write_data,
    output rdy,
    output valid,
    output read_data,
    output error
  );

endinterface

// File: rtl/sdram_sync_fifo.sv
// Plain synchronous FIFO of arbitrary entry type; a pushed entry is readable the next cycle.
// DEPTH must be a power of two so the pointers wrap modulo DEPTH on their own.
module sdram_sync_fifo #(
  parameter type         entry_t = logic,
  parameter int unsigned DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO never accepts, even when the head leaves in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Client request queue in front of an SDRAM controller core, one outstanding read at a time.
// Define SDRAM_REQQ_STATS_EN to add stat_rd/stat_wr counters of requests issued to the core.
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rd,
  input  logic [DATA_WIDTH/8-1:0] req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [TAG_W-1:0]        rsp_tag,
`ifdef SDRAM_REQQ_STATS_EN
  output logic [31:0]             stat_rd,
  output logic [31:0]             stat_wr,
`endif
  sdram_req_queue_if.man          sdram_ctrl_if
);

  req_entry_t              push_entry;
  req_entry_t              head;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  req_state_e              state_q, state_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    core_rd;
  logic [DATA_WIDTH/8-1:0] core_wr;
  logic [ADDR_WIDTH-1:0]   core_addr;
  logic [DATA_WIDTH-1:0]   core_wdata;
  logic                    unused_sig;

  // Held low during reset even though the FIFO count is only cleared at the edge.
  assign req_ready = ~rst & ~fifo_full;

  // Empty requests are acknowledged to the client but never stored.
  assign push_entry = make_entry(req_rd, MaxBeWidth'(req_wr), MaxAddrWidth'(req_addr),
                                 MaxDataWidth'(req_wdata), MaxTagWidth'(req_tag));
  assign fifo_push  = req_valid & req_ready & is_real_req(req_rd, MaxBeWidth'(req_wr));

  sdram_sync_fifo #(
    .entry_t (req_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    fifo_pop   = 1'b0;
    core_rd    = 1'b0;
    core_wr    = '0;
    core_addr  = '0;
    core_wdata = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_tag    = '0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          core_rd    = head.rd;
          core_wr    = head.wr[DATA_WIDTH/8-1:0];
          core_addr  = head.addr[ADDR_WIDTH-1:0];
          core_wdata = head.wdata[DATA_WIDTH-1:0];
          if (sdram_ctrl_if.rdy) begin
            fifo_pop = 1'b1;
            if (head.rd) begin
              state_d = StWaitRd;
              tag_d   = head.tag[TAG_W-1:0];
            end
          end
        end
      end
      StWaitRd: begin
        if (sdram_ctrl_if.valid) begin
          rsp_valid = 1'b1;
          rsp_data  = sdram_ctrl_if.read_data;
          rsp_tag   = tag_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset drops an in-flight read: nothing reaches the client or the core.
    if (rst) begin
      fifo_pop  = 1'b0;
      core_rd   = 1'b0;
      core_wr   = '0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_tag   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign sdram_ctrl_if.rd         = core_rd;
  assign sdram_ctrl_if.wr         = core_wr;
  assign sdram_ctrl_if.addr       = core_addr;
  assign sdram_ctrl_if.write_data = core_wdata;

`ifdef SDRAM_REQQ_STATS_EN
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else if (fifo_pop) begin
      if (head.rd) begin
        stat_rd_q <= stat_rd_q + 32'd1;
      end else begin
        stat_wr_q <= stat_wr_q + 32'd1;
      end
    end
  end

  assign stat_rd = stat_rd_q;
  assign stat_wr = stat_wr_q;
`endif

  // Core error is not acted on; the upper entry bits exist only for wider cores.
  assign unused_sig = ^{head, sdram_ctrl_if.error};

endmodule
